// File: rtl/alu_pkg.sv
// Shared types for the registered datapath ALU: opcode encoding, flag bundle and default width.
package alu_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [3:0] {
        OP_PASS  = 4'd0,
        OP_INC   = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_DEC   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_NOT   = 4'd7,
        OP_NEG   = 4'd8,
        OP_SHL   = 4'd9,
        OP_SHR   = 4'd10,
        OP_ASR   = 4'd11,
        OP_XOR   = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared W+1-bit adder for ADD/SUB/INC/DEC/NEG. Subtraction is x + ~y + 1; carry is
// reported as a borrow (inverted carry-out) when subtracting.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int unsigned PARAM_WIDTH = DefaultWidth
) (
    input  logic [PARAM_WIDTH-1:0] op_x,
    input  logic [PARAM_WIDTH-1:0] op_y,
    input  logic                   sub,
    output logic [PARAM_WIDTH-1:0] sum,
    output logic                   carry,
    output logic                   ovf
);

    localparam int unsigned W = PARAM_WIDTH;

    logic [W-1:0] y_eff;
    logic [W:0]   sum_full;

    always_comb begin
        y_eff    = sub ? ~op_y : op_y;
        sum_full = {1'b0, op_x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
        sum      = sum_full[W-1:0];
        carry    = sub ? ~sum_full[W] : sum_full[W];
        // Overflow judged against the effective (possibly inverted) second operand.
        ovf      = (op_x[W-1] == y_eff[W-1]) && (sum_full[W-1] != op_x[W-1]);
    end

endmodule

// File: rtl/alu_unit.sv
// Registered N-bit ALU: decodes one opcode per cycle, result and z/c/n/v flags are
// captured on the same rising edge that samples the operands.
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned PARAM_WIDTH = DefaultWidth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PARAM_WIDTH-1:0] a,
    input  logic [PARAM_WIDTH-1:0] b,
    input  logic [3:0]             opcode,
    output logic [PARAM_WIDTH-1:0] y,
    output logic                   z,
    output logic                   c,
    output logic                   n,
    output logic                   v
);

    localparam int unsigned W = PARAM_WIDTH;
    localparam logic [W-1:0] One  = W'(1);
    localparam logic [W-1:0] Zero = '0;

    alu_op_e op;

    logic [W-1:0] as_x;
    logic [W-1:0] as_y;
    logic         as_sub;
    logic [W-1:0] as_sum;
    logic         as_carry;
    logic         as_ovf;

    logic [W-1:0] y_d;
    logic [W-1:0] y_q;
    alu_flags_t   flags_d;
    alu_flags_t   flags_q;

    assign op = alu_op_e'(opcode);

    // Operand steering for the shared adder; non-arithmetic opcodes leave it idle on a + b.
    always_comb begin
        as_x   = a;
        as_y   = b;
        as_sub = 1'b0;
        case (op)
            OP_INC: begin
                as_y   = One;
            end
            OP_SUB: begin
                as_sub = 1'b1;
            end
            OP_DEC: begin
                as_y   = One;
                as_sub = 1'b1;
            end
            OP_NEG: begin
                as_x   = Zero;
                as_y   = a;
                as_sub = 1'b1;
            end
            default: ;
        endcase
    end

    alu_addsub #(
        .PARAM_WIDTH(W)
    ) u_addsub (
        .op_x  (as_x),
        .op_y  (as_y),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    always_comb begin
        y_d       = Zero;
        flags_d   = '0;
        case (op)
            OP_PASS: y_d = a;
            OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_NEG: begin
                y_d       = as_sum;
                flags_d.c = as_carry;
                flags_d.v = as_ovf;
            end
            OP_AND:  y_d = a & b;
            OP_OR:   y_d = a | b;
            OP_NOT:  y_d = ~a;
            OP_XOR:  y_d = a ^ b;
            OP_SHL: begin
                y_d       = {a[W-2:0], 1'b0};
                flags_d.c = a[W-1];
            end
            OP_SHR: begin
                y_d       = {1'b0, a[W-1:1]};
                flags_d.c = a[0];
            end
            OP_ASR: begin
                y_d       = {a[W-1], a[W-1:1]};
                flags_d.c = a[0];
            end
            default: y_d = Zero;
        endcase
        flags_d.z = (y_d == Zero);
        flags_d.n = y_d[W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= Zero;
            flags_q <= '0;
        end else begin
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign y = y_q;
    assign z = flags_q.z;
    assign c = flags_q.c;
    assign n = flags_q.n;
    assign v = flags_q.v;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expectations are queued at drive time and checked one
// edge later, using directed constants and an independent integer-arithmetic model.
module tb_alu_unit;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic [W-1:0] y;
    logic         z;
    logic         c;
    logic         n;
    logic         v;

    typedef struct {
        string        tag;
        logic [W-1:0] y;
        logic [3:0]   f;  // {z, c, n, v}
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drive_done = 0;

    alu_unit #(
        .PARAM_WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .y      (y),
        .z      (z),
        .c      (c),
        .n      (n),
        .v      (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model written from the opcode table using signed integer range checks.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] q);
        logic [W-1:0] r;
        logic         fc;
        logic         fv;
        int           sx;
        int           sq;
        int           t;
        sx = int'($signed(x));
        sq = int'($signed(q));
        r  = '0;
        fc = 1'b0;
        fv = 1'b0;
        case (op)
            4'd0:  r = x;
            4'd1:  begin r = x + 8'd1; fc = (x == 8'hFF); fv = (x == 8'h7F); end
            4'd2:  begin
                r = x + q; fc = (int'(x) + int'(q)) > 255;
                t = sx + sq; fv = (t > 127) || (t < -128);
            end
            4'd3:  begin
                r = x - q; fc = (x < q);
                t = sx - sq; fv = (t > 127) || (t < -128);
            end
            4'd4:  begin r = x - 8'd1; fc = (x == 8'h00); fv = (x == 8'h80); end
            4'd5:  r = x & q;
            4'd6:  r = x | q;
            4'd7:  r = ~x;
            4'd8:  begin r = 8'd0 - x; fc = (x != 8'h00); fv = (x == 8'h80); end
            4'd9:  begin r = x << 1; fc = x[7]; end
            4'd10: begin r = x >> 1; fc = x[0]; end
            4'd11: begin r = W'($signed(x) >>> 1); fc = x[0]; end
            4'd12: r = x ^ q;
            default: r = '0;
        endcase
        return {r, (r == 8'h00), fc, r[7], fv};
    endfunction

    task automatic drive_exp(input string tag, input logic rst, input logic [3:0] op,
                             input logic [W-1:0] x, input logic [W-1:0] q,
                             input logic [W-1:0] ey, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        opcode = op;
        a      = x;
        b      = q;
        e.tag  = tag;
        e.y    = ey;
        e.f    = ef;
        sb_q.push_back(e);
    endtask

    task automatic drive_model(input string tag, input logic rst, input logic [3:0] op,
                               input logic [W-1:0] x, input logic [W-1:0] q);
        logic [11:0] m;
        m = rst ? model(op, x, q) : 12'h000;
        drive_exp(tag, rst, op, x, q, m[11:4], m[3:0]);
    endtask

    // Monitor: one edge after each drive, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq({e.tag, ".y"}, 32'(y), 32'(e.y));
                check_eq({e.tag, ".zcnv"}, 32'({z, c, n, v}), 32'(e.f));
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        opcode = 4'd2;
        a      = 8'hFC;
        b      = 8'h07;
        //                                             y       zcnv
        drive_exp("rst",      1'b0, 4'd2,  8'hFC, 8'h07, 8'h00, 4'b0000);
        drive_exp("add_fc07", 1'b1, 4'd2,  8'hFC, 8'h07, 8'h03, 4'b0100);
        drive_exp("sub_5_8",  1'b1, 4'd3,  8'h05, 8'h08, 8'hFD, 4'b0110);
        drive_exp("sub_80_1", 1'b1, 4'd3,  8'h80, 8'h01, 8'h7F, 4'b0001);
        drive_exp("inc_7f",   1'b1, 4'd1,  8'h7F, 8'h55, 8'h80, 4'b0011);
        drive_exp("dec_00",   1'b1, 4'd4,  8'h00, 8'h55, 8'hFF, 4'b0110);
        drive_exp("and",      1'b1, 4'd5,  8'd100, 8'd50, 8'h20, 4'b0000);
        drive_exp("or",       1'b1, 4'd6,  8'd23, 8'd31, 8'h1F, 4'b0000);
        drive_exp("not_2e",   1'b1, 4'd7,  8'h2E, 8'hFF, 8'hD1, 4'b0010);
        drive_exp("pass_0",   1'b1, 4'd0,  8'h00, 8'hAA, 8'h00, 4'b1000);
        drive_exp("neg_f3",   1'b1, 4'd8,  8'hF3, 8'h00, 8'h0D, 4'b0100);
        drive_exp("neg_80",   1'b1, 4'd8,  8'h80, 8'h00, 8'h80, 4'b0111);
        drive_exp("shl_42",   1'b1, 4'd9,  8'd42, 8'h00, 8'd84, 4'b0000);
        drive_exp("shl_81",   1'b1, 4'd9,  8'h81, 8'h00, 8'h02, 4'b0100);
        drive_exp("asr_81",   1'b1, 4'd11, 8'h81, 8'h00, 8'hC0, 4'b0110);
        drive_exp("shr_81",   1'b1, 4'd10, 8'h81, 8'h00, 8'h40, 4'b0100);
        drive_exp("xor",      1'b1, 4'd12, 8'hA5, 8'h5A, 8'hFF, 4'b0010);
        drive_exp("rsv14",    1'b1, 4'd14, 8'hFF, 8'hFF, 8'h00, 4'b1000);
        drive_exp("dec_80",   1'b1, 4'd4,  8'h80, 8'h00, 8'h7F, 4'b0001);
        drive_exp("inc_ff",   1'b1, 4'd1,  8'hFF, 8'h00, 8'h00, 4'b1100);
        drive_exp("mid_rst",  1'b0, 4'd7,  8'h00, 8'h00, 8'h00, 4'b0000);
        drive_exp("add_ovf",  1'b1, 4'd2,  8'h7F, 8'h01, 8'h80, 4'b0011);

        for (int i = 0; i < 80; i++) begin
            drive_model($sformatf("rnd%0d", i), (i != 40), 4'($urandom_range(0, 15)),
                        8'($urandom), 8'($urandom));
        end
        for (int op = 0; op < 16; op++) begin
            drive_model($sformatf("edge_op%0d_80", op), 1'b1, 4'(op), 8'h80, 8'h7F);
            drive_model($sformatf("edge_op%0d_01", op), 1'b1, 4'(op), 8'h01, 8'hFF);
        end

        repeat (4) @(posedge clk);
        #2;
        check_eq("drain", 32'(sb_q.size()), 32'd0);
        drive_done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!drive_done) begin
            $display("FAIL timeout got=running exp=finished");
            $fatal(1, "timeout");
        end
    end

endmodule
